andn_seq_reducer: RTL and testbench



---
 rtl/andn_pkg.sv | 19 +
 rtl/andn_chunk.sv | 23 ++
 rtl/andn_seq_reducer.sv | 91 +++++++++
 tb/tb_andn_seq_reducer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/andn_pkg.sv
// Shared types and helpers for the sequential AND reducer.
package andn_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} andn_state_t;

  // Widest chunk the helper can scan; callers pad unused upper bits with ones.
  localparam int MAXCHUNK = 64;

  // Position of the lowest zero bit in c; 0 when c is all ones.
  function automatic int lowest_zero(input logic [MAXCHUNK-1:0] c);
    int pos;
    pos = 0;
    for (int i = MAXCHUNK - 1; i >= 0; i--) begin
      if (!c[i]) pos = i;
    end
    return pos;
  endfunction

endpackage

// File: rtl/andn_chunk.sv
// Combinational per-chunk reduction: all-ones flag and lowest zero position.
module andn_chunk
  import andn_pkg::*;
#(
  parameter  int CHUNK = 4,
  localparam int ZW    = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0] chunk,
  output logic             all_ones,
  output logic [ZW-1:0]    zero_pos
);

  logic [MAXCHUNK-1:0] ext;

  // Pad to the helper width with ones so padding never reports a zero.
  always_comb begin
    ext              = '1;
    ext[CHUNK-1:0]   = chunk;
    all_ones         = &chunk;
    zero_pos         = ZW'(lowest_zero(ext));
  end

endmodule

// File: rtl/andn_seq_reducer.sv
// Handshaked AND reducer: scans a latched word CHUNK bits per cycle and
// stops at the first chunk that holds a zero.
module andn_seq_reducer
  import andn_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int CHUNK = 4,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic [IW-1:0]    out_zero_idx,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int ZW     = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  andn_state_t      state;
  logic [WIDTH-1:0] word;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] shifted;
  logic [CHUNK-1:0] cur;
  logic             all_ones;
  logic [ZW-1:0]    zpos;
  logic             last;

  // Select the chunk addressed by the counter.
  always_comb begin
    shifted = word >> (int'(k) * CHUNK);
    cur     = shifted[CHUNK-1:0];
    last    = (int'(k) == NCHUNK - 1);
  end

  andn_chunk #(.CHUNK(CHUNK)) u_chunk (
    .chunk    (cur),
    .all_ones (all_ones),
    .zero_pos (zpos)
  );

  // Control FSM with word, counter and result registers; reset drops any
  // in-flight result so it is never emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      word         <= '0;
      k            <= '0;
      out_y        <= 1'b0;
      out_zero_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word  <= in_data;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (!all_ones) begin
            out_y        <= 1'b0;
            out_zero_idx <= IW'(int'(k) * CHUNK + int'(zpos));
            state        <= DONE;
          end else if (last) begin
            out_y        <= 1'b1;
            out_zero_idx <= '0;
            state        <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_andn_seq_reducer.sv
// Bench for andn_seq_reducer: a 16/4 instance and an 8/1 bit-serial instance.
module tb_andn_seq_reducer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv0, ir0, ov0, or0, y0, busy0;
  logic [15:0] id0;
  logic [3:0]  zi0;
  logic        iv1, ir1, ov1, or1, y1, busy1;
  logic [7:0]  id1;
  logic [2:0]  zi1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  andn_seq_reducer #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_y(y0), .out_zero_idx(zi0), .busy(busy0)
  );

  andn_seq_reducer #(.WIDTH(8), .CHUNK(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_y(y1), .out_zero_idx(zi1), .busy(busy1)
  );

  typedef struct {
    logic [15:0] d;
    int          hold;
    bit          y;
    int          idx;
    int          lat;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int g_ov(input int s);   return s ? int'(ov1) : int'(ov0); endfunction
  function automatic int g_ir(input int s);   return s ? int'(ir1) : int'(ir0); endfunction
  function automatic int g_y(input int s);    return s ? int'(y1)  : int'(y0);  endfunction
  function automatic int g_zi(input int s);   return s ? int'(zi1) : int'(zi0); endfunction
  function automatic int g_busy(input int s); return s ? int'(busy1) : int'(busy0); endfunction

  task automatic set_in(input int s, input bit v, input logic [15:0] d);
    if (s != 0) begin iv1 = v; id1 = d[7:0]; end
    else        begin iv0 = v; id0 = d;      end
  endtask

  task automatic set_or(input int s, input bit v);
    if (s != 0) or1 = v; else or0 = v;
  endtask

  // Reference: AND of the word is "no zero bit"; the result appears once the
  // chunk holding the lowest zero (or the last chunk) has been examined.
  task automatic model(input logic [15:0] d, input int w, input int c,
                       output bit y, output int idx, output int lat);
    y = 1'b1;
    idx = 0;
    for (int i = 0; i < w; i++) begin
      if (y && !d[i]) begin y = 1'b0; idx = i; end
    end
    lat = y ? (w / c) : (idx / c + 1);
  endtask

  // One word through instance s, with out_ready low for 'hold' cycles of DONE.
  task automatic xact(input int s, input logic [15:0] data, input int hold,
                      input bit ey, input int ei, input int el, input string name);
    int lat;
    int ry, ri;
    bit stable;
    @(negedge clk);
    chk({name, "_in_ready_idle"}, g_ir(s), 1);
    set_in(s, 1'b1, data);
    set_or(s, hold == 0);
    @(posedge clk);
    #1;
    set_in(s, 1'b0, 16'($urandom));
    lat = 0;
    while (g_ov(s) == 0 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, lat, el);
    chk({name, "_y"}, g_y(s), int'(ey));
    chk({name, "_idx"}, g_zi(s), ei);
    if (hold > 0) begin
      ry = g_y(s);
      ri = g_zi(s);
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (g_ov(s) != 1 || g_y(s) != ry || g_zi(s) != ri || g_ir(s) != 0) stable = 1'b0;
      end
      chk({name, "_stable_under_backpressure"}, int'(stable), 1);
      @(negedge clk);
      set_or(s, 1'b1);
    end
    @(posedge clk);
    #1;
    chk({name, "_valid_dropped"}, g_ov(s), 0);
    chk({name, "_ready_back"}, g_ir(s), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ey;
    int   ei, el, hs, lat, mode, s, hold;
    bit   seen;
    logic [15:0] d;

    tbl[0] = '{16'hFFFF, 0, 1'b1, 0,  4};
    tbl[1] = '{16'hFFBF, 0, 1'b0, 6,  2};
    tbl[2] = '{16'h0000, 5, 1'b0, 0,  1};
    tbl[3] = '{16'hFF0F, 0, 1'b0, 4,  2};
    tbl[4] = '{16'h0FFF, 0, 1'b0, 12, 4};
    tbl[5] = '{16'hFFF7, 2, 1'b0, 3,  1};
    tbl[6] = '{16'hBFFF, 0, 1'b0, 14, 4};
    tbl[7] = '{16'hFFFE, 0, 1'b0, 0,  1};
    tbl[8] = '{16'hF7FF, 1, 1'b0, 11, 3};

    iv0 = 1'b0; id0 = '0; or0 = 1'b1;
    iv1 = 1'b0; id1 = '0; or1 = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(ir0), 1);
    chk("rst_out_valid", int'(ov0), 0);
    chk("rst_out_y", int'(y0), 0);
    chk("rst_zero_idx", int'(zi0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_busy_serial", int'(busy1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      xact(0, tbl[i].d, tbl[i].hold, tbl[i].y, tbl[i].idx, tbl[i].lat, $sformatf("vec%0d", i));

    // Reset in the middle of a scan discards the word.
    @(negedge clk);
    set_in(0, 1'b1, 16'hFFFF);
    or0 = 1'b1;
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("midrst_busy_before", int'(busy0), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_in_ready", int'(ir0), 1);
    chk("midrst_out_y", int'(y0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ov0 || busy0) seen = 1'b1;
    end
    chk("midrst_no_result", int'(seen), 0);
    xact(0, 16'h7FFF, 0, 1'b0, 15, 4, "after_rst");

    // Bit-serial instance with in_valid held high while busy.
    @(negedge clk);
    set_in(1, 1'b1, 16'h00F7);
    or1 = 1'b1;
    hs = 0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (ov1) break;
      if (ir1) hs++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("serial_handshakes", hs, 1);
    chk("serial_latency", lat, 4);
    chk("serial_y", int'(y1), 0);
    chk("serial_idx", int'(zi1), 3);
    set_in(1, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    chk("serial_valid_dropped", int'(ov1), 0);
    xact(1, 16'h00FF, 0, 1'b1, 0, 8, "serial_ones");

    // Randomized words against the reference on both instances.
    for (int i = 0; i < 120; i++) begin
      s = i % 2;
      mode = $urandom_range(0, 3);
      case (mode)
        0: d = 16'($urandom);
        1: d = 16'hFFFF;
        2: begin d = 16'hFFFF; d[$urandom_range(0, s ? 7 : 15)] = 1'b0; end
        default: d = 16'($urandom) | 16'h00FF;
      endcase
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      model(d, s ? 8 : 16, s ? 1 : 4, ey, ei, el);
      xact(s, d, hold, ey, ei, el, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
